// File: rtl/ppu_pixel_timing_gen_if.sv
// Pixel stream from the PPU timing generator toward the VGA path.
// The master drives the FIFO head and valid flag; the slave drives ready.
interface ppu_pixel_timing_gen_if #(
    parameter int COLOR_W = 6
);
    logic [COLOR_W-1:0] VGA_STREAM_DATA;
    logic               VGA_STREAM_SOF;
    logic               VGA_STREAM_VALID;
    logic               VGA_STREAM_READY;

    modport master (
        output VGA_STREAM_DATA,
        output VGA_STREAM_SOF,
        output VGA_STREAM_VALID,
        input  VGA_STREAM_READY
    );

    modport slave (
        input  VGA_STREAM_DATA,
        input  VGA_STREAM_SOF,
        input  VGA_STREAM_VALID,
        output VGA_STREAM_READY
    );
endinterface

// File: rtl/ppu_pixel_timing_gen.sv
// PPU raster timing: dot/line counters, VBLANK/NMI, odd-frame dot skip and a
// small FIFO that buffers visible pixels toward the VGA stream.
module ppu_pixel_timing_gen #(
    parameter int H_VISIBLE      = 256,
    parameter int H_TOTAL        = 341,
    parameter int V_VISIBLE      = 240,
    parameter int V_TOTAL        = 262,
    parameter int VBLANK_LINE    = 241,
    parameter int PRERENDER_LINE = 261,
    parameter int COLOR_W        = 6,
    parameter int FIFO_DEPTH     = 8,
    parameter int ODD_SKIP       = 1
) (
    input  logic                       PPU_SLOW_CLOCK,
    input  logic                       RST_N,
    input  logic                       RENDER_EN,
    input  logic                       NMI_EN,
    input  logic                       STATUS_RD,
    input  logic [COLOR_W-1:0]         PIX_COLOR,
    input  logic [COLOR_W-1:0]         BACKDROP,
    output logic [$clog2(H_TOTAL)-1:0] PIXEL_X,
    output logic [$clog2(V_TOTAL)-1:0] PIXEL_Y,
    output logic                       VISIBLE,
    output logic                       VBLANK,
    output logic                       NMI,
    output logic                       FRAME_ODD,
    ppu_pixel_timing_gen_if.master     VGA_STREAM,
    output logic                       FIFO_OVERFLOW
);
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_SKIP = XW'(H_TOTAL - 2);
    localparam logic [XW-1:0] X_VIS  = XW'(H_VISIBLE);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS  = YW'(V_VISIBLE);
    localparam logic [YW-1:0] Y_VBL  = YW'(VBLANK_LINE);
    localparam logic [YW-1:0] Y_PRE  = YW'(PRERENDER_LINE);

    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           odd_q, odd_d;
    logic           vblank_q, vblank_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic           ovf_q, ovf_d;
    logic [COLOR_W:0] mem_q [FIFO_DEPTH];

    logic           skip;
    logic           visible;
    logic           empty;
    logic           full;
    logic           pop;
    logic           wr_en;
    logic [COLOR_W:0] wr_data;
    logic [COLOR_W:0] head;

    // Raster counters, including the shortened odd frame while rendering.
    always_comb begin
        x_d   = x_q + 1'b1;
        y_d   = y_q;
        odd_d = odd_q;
        skip  = (ODD_SKIP != 0) && RENDER_EN && odd_q && (x_q == X_SKIP) && (y_q == Y_PRE);
        if (skip) begin
            x_d   = '0;
            y_d   = '0;
            odd_d = ~odd_q;
        end else if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
                y_d   = '0;
                odd_d = ~odd_q;
            end else begin
                y_d = y_q + 1'b1;
            end
        end
    end

    // A status read wins over the set edge, which is what suppresses the frame's NMI.
    always_comb begin
        vblank_d = vblank_q;
        if (STATUS_RD) begin
            vblank_d = 1'b0;
        end else if ((x_q == X_ONE) && (y_q == Y_VBL)) begin
            vblank_d = 1'b1;
        end else if ((x_q == X_ONE) && (y_q == Y_PRE)) begin
            vblank_d = 1'b0;
        end
    end

    assign visible = (x_q < X_VIS) && (y_q < Y_VIS);
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && VGA_STREAM.VGA_STREAM_READY;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign wr_en   = visible && (!full || pop);
    assign wr_data = {((x_q == '0) && (y_q == '0)), (RENDER_EN ? PIX_COLOR : BACKDROP)};

    always_comb begin
        wr_d  = wr_q + PW'(wr_en);
        rd_d  = rd_q + PW'(pop);
        ovf_d = ovf_q | (visible && full && !pop);
    end

    always_ff @(posedge PPU_SLOW_CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            x_q      <= '0;
            y_q      <= '0;
            odd_q    <= 1'b0;
            vblank_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            odd_q    <= odd_d;
            vblank_q <= vblank_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= wr_data;
        end
    end

    // Head is gated while empty so DATA/SOF read zero out of reset.
    assign head = mem_q[rd_q[AW-1:0]];

    assign VGA_STREAM.VGA_STREAM_DATA  = empty ? '0 : head[COLOR_W-1:0];
    assign VGA_STREAM.VGA_STREAM_SOF   = empty ? 1'b0 : head[COLOR_W];
    assign VGA_STREAM.VGA_STREAM_VALID = !empty;

    assign PIXEL_X       = x_q;
    assign PIXEL_Y       = y_q;
    assign VISIBLE       = visible;
    assign VBLANK        = vblank_q;
    assign NMI           = vblank_q & NMI_EN;
    assign FRAME_ODD     = odd_q;
    assign FIFO_OVERFLOW = ovf_q;
endmodule
